// File: rtl/gpp_ir_pkg.sv
// Shared defaults for the instruction register / prefetch queue:
// widths, decoded-field offsets and the instruction word type.
package gpp_ir_pkg;

  localparam int IW_DEF    = 16;
  localparam int OPW_DEF   = 6;
  localparam int DEPTH_DEF = 4;

  // Field offsets for the default word layout
  localparam int OPC_LSB = IW_DEF - OPW_DEF;
  localparam int RA_BIT  = IW_DEF - OPW_DEF - 1;
  localparam int RAS_MSB = RA_BIT;

  typedef logic [IW_DEF-1:0] instr_t;

endpackage

// File: rtl/ir_fifo.sv
// Circular buffer feeding the instruction register: push/pop/clear,
// occupancy count and head data.
module ir_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] qcnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      qcnt   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      qcnt <= qcnt + QW'(1);
      else if (pop && !push) qcnt <= qcnt - QW'(1);
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register with prefetch queue, bypass path and field decode.
// Optional head-peek outputs (next_out/next_valid) enabled by IR_PEEK_EN.
module ir_prefetch_queue
  import gpp_ir_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IW-1:0]               in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        pop,
  input  logic                        flush,
  output logic [IW-1:0]               out,
  output logic                        out_valid,
  output logic [OPW-1:0]              opcode,
  output logic                        RA,
  output logic [IW-OPW-1:0]           BA,
  output logic [IW-OPW-2:0]           IMM,
  output logic [1:0]                  RA_stack,
`ifdef IR_PEEK_EN
  output logic [IW-1:0]               next_out,
  output logic                        next_valid,
`endif
  output logic [$clog2(DEPTH+2)-1:0]  count
);

  localparam int QW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + 2);

  logic [IW-1:0] head;
  logic [QW-1:0] qcnt;
  logic          q_nonempty;
  logic          accept;
  logic          load;
  logic          fifo_pop;
  logic          fifo_push;
  logic          bypass;

  assign q_nonempty = (qcnt != '0);
  assign in_ready   = rst && !flush && (qcnt < QW'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign load       = !out_valid || pop;

  // in_ready already excludes flush, so only the read side needs gating.
  assign fifo_pop  = load && q_nonempty && !flush;
  assign bypass    = load && !q_nonempty && accept;
  assign fifo_push = accept && !bypass;

  ir_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (in),
    .pop       (fifo_pop),
    .head      (head),
    .qcnt      (qcnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      if (q_nonempty) begin
        out       <= head;
        out_valid <= 1'b1;
      end else if (accept) begin
        out       <= in;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign opcode   = out[IW-1 -: OPW];
  assign RA       = out[IW-OPW-1];
  assign BA       = out[IW-OPW-1:0];
  assign IMM      = out[IW-OPW-2:0];
  assign RA_stack = out[IW-OPW-1 -: 2];
  assign count    = CW'(qcnt) + CW'(out_valid);

`ifdef IR_PEEK_EN
  assign next_out   = q_nonempty ? head : '0;
  assign next_valid = q_nonempty;
`endif

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Randomized bench for ir_prefetch_queue against a queue-based reference model.
module tb_ir_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic [5:0]  opcode;
  logic        RA;
  logic [9:0]  BA;
  logic [8:0]  IMM;
  logic [1:0]  RA_stack;
  logic [2:0]  count;
`ifdef IR_PEEK_EN
  logic [15:0] next_out;
  logic        next_valid;
`endif

  ir_prefetch_queue #(.IW(16), .OPW(6), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pop       (pop),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .opcode    (opcode),
    .RA        (RA),
    .BA        (BA),
    .IMM       (IMM),
    .RA_stack  (RA_stack),
`ifdef IR_PEEK_EN
    .next_out  (next_out),
    .next_valid(next_valid),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: instruction register plus an unbounded-style queue capped at 4.
  logic [15:0] m_ir  = '0;
  logic        m_ov  = 1'b0;
  logic [15:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] w, input logic iv,
                      input logic p, input logic f);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    rst = r; in = w; in_valid = iv; pop = p; flush = f;
    #1;
    exp_rdy = r && !f && (m_q.size() < 4);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    acc = iv && exp_rdy;
    if (!r) begin
      m_ir = '0; m_ov = 1'b0; m_q.delete();
    end else if (f) begin
      m_ov = 1'b0; m_q.delete();
    end else if (!m_ov || p) begin
      if (m_q.size() > 0) begin
        m_ir = m_q.pop_front(); m_ov = 1'b1;
        if (acc) m_q.push_back(w);
      end else if (acc) begin
        m_ir = w; m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end else if (acc) begin
      m_q.push_back(w);
    end
    #1;
    check("out", 32'(out), 32'(m_ir));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("count", 32'(count), 32'(m_q.size()) + 32'(m_ov));
    check("opcode", 32'(opcode), 32'(m_ir[15:10]));
    check("RA", 32'(RA), 32'(m_ir[9]));
    check("BA", 32'(BA), 32'(m_ir[9:0]));
    check("IMM", 32'(IMM), 32'(m_ir[8:0]));
    check("RA_stack", 32'(RA_stack), 32'(m_ir[9:8]));
`ifdef IR_PEEK_EN
    check("next_valid", 32'(next_valid), 32'(m_q.size() > 0));
    check("next_out", 32'(next_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
`endif
  endtask

  initial begin
    // Reset
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);

    // Bypass into empty register
    step(1'b1, 16'b0110101010110011, 1'b1, 1'b0, 1'b0);
    check("byp_opcode", 32'(opcode), 32'b011010);
    check("byp_RA", 32'(RA), 32'h1);
    check("byp_BA", 32'(BA), 32'b1010110011);
    check("byp_IMM", 32'(IMM), 32'b010110011);
    check("byp_RA_stack", 32'(RA_stack), 32'b10);
    check("byp_count", 32'(count), 32'h1);

    // Hold, then pop
    step(1'b1, 16'b0001011011110100, 1'b1, 1'b0, 1'b0);
    check("hold_out", 32'(out), 32'b0110101010110011);
    check("hold_count", 32'(count), 32'h2);
    step(1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    check("pop_out", 32'(out), 32'b0001011011110100);
    check("pop_opcode", 32'(opcode), 32'b000101);

    // Fill to DEPTH behind the register, then drain in order
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'hA000 + i), 1'b1, 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'h5);
    check("fill_ready", 32'(in_ready), 32'h0);
    step(1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    check("fill_ready_after_pop", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(out_valid), 32'h0);

    // Flush with three queued words overrides pop and in_valid
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hB000 + i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_out", 32'(out), 32'hB000);

    // Streaming: one word per cycle, count stays 1
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b1, 1'b0);
      check("stream_out", 32'(out), 32'(i));
      check("stream_count", 32'(count), 32'h1);
    end

    // Randomized traffic including occasional reset and flush
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           16'($urandom()),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
